// File: rtl/vgaminikbd_pkg.sv
// Shared definitions for the VGA / keyboard front end.
// Holds the ANSI escape byte constants, the escape-lock state type and
// the lock state transition function used by the command arbiter.
package vgaminikbd_pkg;

  localparam logic [7:0] ESC       = 8'h1B;
  localparam logic [7:0] CSI_INTRO = 8'h5B;
  localparam logic [7:0] FINAL_LO  = 8'h40;
  localparam logic [7:0] FINAL_HI  = 8'h7E;
  localparam logic [7:0] PARAM_LO  = 8'h20;
  localparam logic [7:0] PARAM_HI  = 8'h3F;

  // Members carry a LOCK_ prefix so they do not collide with the ESC byte constant.
  typedef enum logic [1:0] {
    LOCK_IDLE = 2'd0,
    LOCK_ESC  = 2'd1,
    LOCK_CSI  = 2'd2
  } lockState_t;

  // Next lock state after a source-0 byte has been loaded for output.
  function automatic lockState_t nextLockState(input lockState_t cur, input logic [7:0] b);
    lockState_t nxt;
    nxt = LOCK_IDLE;
    case (cur)
      LOCK_IDLE: nxt = (b == ESC) ? LOCK_ESC : LOCK_IDLE;
      LOCK_ESC:  nxt = (b == CSI_INTRO) ? LOCK_CSI : LOCK_IDLE;
      LOCK_CSI: begin
        if (b >= PARAM_LO && b <= PARAM_HI)      nxt = LOCK_CSI;   // parameter/intermediate byte
        else if (b >= FINAL_LO && b <= FINAL_HI) nxt = LOCK_IDLE;  // final byte ends the sequence
        else if (b == ESC)                       nxt = LOCK_ESC;   // new escape restarts
        else                                     nxt = LOCK_IDLE;  // anything else aborts
      end
      default: nxt = LOCK_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Purpose: synchronous DEPTH x 8 byte FIFO with full/empty flags.
// Latency: a pushed byte is visible on rdData the cycle after the push edge.
// Backpressure: push is refused when full unless a pop happens in the same cycle.
// Ports: clk/resetn; push+wrData write side; pop/rdData read side (rdData shows
//        the oldest stored byte, a byte pushed this cycle never falls through);
//        full/empty status.
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       push,
  input  logic [7:0] wrData,
  input  logic       pop,
  output logic [7:0] rdData,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0]   count;
  logic          wrEn;
  logic          rdEn;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign rdData = mem[rdPtr];

  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign wrEn = push && (!full || pop);
  assign rdEn = pop && !empty;

  always_ff @(posedge clk) begin
    if (wrEn) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + AW'(1);
      if (rdEn) rdPtr <= rdPtr + AW'(1);
      case ({wrEn, rdEn})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_cmd_arbiter.sv
// Purpose: merge serial ANSI bytes (src 0) and keyboard echo (src 1) onto the VGA port.
// Latency: byte pushed in cycle N appears on od/odv in cycle N+2; 1 byte/cycle sustained.
// Backpressure: od held while odv && !odReady; FIFOs absorb, full FIFO drops and flags ovf*.
// Ports: clk/resetn; d0/d0v serial source; d1/d1v keyboard source; od/odv/odReady
//        output handshake; errClr clears ovf0/ovf1; lockTimeout pulse; locked status.
module vga_cmd_arbiter
  import vgaminikbd_pkg::*;
#(
  parameter int DEPTH        = 8,
  parameter int LOCK_TIMEOUT = 24000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] d0,
  input  logic       d0v,
  input  logic [7:0] d1,
  input  logic       d1v,
  output logic [7:0] od,
  output logic       odv,
  input  logic       odReady,
  input  logic       errClr,
  output logic       ovf0,
  output logic       ovf1,
  output logic       lockTimeout,
  output logic       locked
);

  localparam int CW = $clog2(LOCK_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = CW'(LOCK_TIMEOUT - 1);

  logic [7:0] f0Data, f1Data;
  logic       f0Full, f0Empty, f1Full, f1Empty;
  logic       pop0, pop1;
  logic       elig0, elig1, canLoad, load, pick1;
  logic       prefer1;
  logic       drop0, drop1, fire;
  lockState_t lockState, lockNext;
  logic [CW-1:0] lockCnt;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo0 (
    .clk    (clk),
    .resetn (resetn),
    .push   (d0v),
    .wrData (d0),
    .pop    (pop0),
    .rdData (f0Data),
    .full   (f0Full),
    .empty  (f0Empty)
  );

  byte_fifo #(.DEPTH(DEPTH)) u_fifo1 (
    .clk    (clk),
    .resetn (resetn),
    .push   (d1v),
    .wrData (d1),
    .pop    (pop1),
    .rdData (f1Data),
    .full   (f1Full),
    .empty  (f1Empty)
  );

  // While an escape sequence is in flight only source 0 may be granted,
  // even if FIFO0 is momentarily empty.
  assign elig0   = !f0Empty;
  assign elig1   = !f1Empty && !locked;
  assign canLoad = !odv || odReady;
  assign pick1   = elig1 && (!elig0 || prefer1);
  assign load    = canLoad && (elig0 || elig1);
  assign pop0    = load && !pick1;
  assign pop1    = load && pick1;

  assign drop0 = d0v && f0Full && !pop0;
  assign drop1 = d1v && f1Full && !pop1;

  assign lockNext = nextLockState(lockState, f0Data);
  // A source-0 load in the same cycle counts as activity and takes precedence.
  assign fire = locked && !pop0 && (lockCnt == CNT_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      od          <= 8'h00;
      odv         <= 1'b0;
      prefer1     <= 1'b0;
      lockState   <= LOCK_IDLE;
      locked      <= 1'b0;
      lockCnt     <= '0;
      lockTimeout <= 1'b0;
      ovf0        <= 1'b0;
      ovf1        <= 1'b0;
    end else begin
      // Output register and round-robin pointer
      if (load) begin
        od      <= pick1 ? f1Data : f0Data;
        odv     <= 1'b1;
        prefer1 <= !pick1;
      end else if (odReady) begin
        odv <= 1'b0;
      end

      // Escape lock FSM and its watchdog
      if (pop0) begin
        lockState <= lockNext;
        locked    <= (lockNext != LOCK_IDLE);
        lockCnt   <= '0;
      end else if (fire) begin
        lockState <= LOCK_IDLE;
        locked    <= 1'b0;
        lockCnt   <= '0;
      end else if (locked) begin
        lockCnt <= lockCnt + CW'(1);
      end
      lockTimeout <= fire;

      // Sticky overflow flags; a new drop beats a clear
      if (drop0)       ovf0 <= 1'b1;
      else if (errClr) ovf0 <= 1'b0;
      if (drop1)       ovf1 <= 1'b1;
      else if (errClr) ovf1 <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_cmd_arbiter.sv
module tb_vga_cmd_arbiter;

  localparam int DEPTH = 8;
  localparam int LT    = 16;
  localparam int NVEC  = 32;

  logic       clk;
  logic       resetn;
  logic [7:0] d0, d1, od;
  logic       d0v, d1v, odv, odReady, errClr;
  logic       ovf0, ovf1, lockTimeout, locked;

  int checks   = 0;
  int failures = 0;

  vga_cmd_arbiter #(.DEPTH(DEPTH), .LOCK_TIMEOUT(LT)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .d0          (d0),
    .d0v         (d0v),
    .d1          (d1),
    .d1v         (d1v),
    .od          (od),
    .odv         (odv),
    .odReady     (odReady),
    .errClr      (errClr),
    .ovf0        (ovf0),
    .ovf1        (ovf1),
    .lockTimeout (lockTimeout),
    .locked      (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       d0v;
    logic [7:0] d0;
    logic       d1v;
    logic [7:0] d1;
    logic       rdy;
    logic       clr;
    logic       eOdv;
    logic [7:0] eOd;
    logic       eLk;
  } vec_t;

  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic v0, input logic [7:0] b0, input logic v1,
                              input logic [7:0] b1, input logic rdy, input logic clr,
                              input logic eOdv, input logic [7:0] eOd, input logic eLk);
    vec_t v;
    v.d0v = v0; v.d0 = b0; v.d1v = v1; v.d1 = b1; v.rdy = rdy; v.clr = clr;
    v.eOdv = eOdv; v.eOd = eOd; v.eLk = eLk;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    int extra;
    logic sawEarly;
    logic stale;

    // Row inputs act during the cycle; expectations are sampled after its closing edge.
    // Round-robin: both sources streaming alternate with no gaps, source 0 first.
    tbl[0]  = mk(1, 8'h30, 1, 8'h61, 1, 0, 0, 8'h00, 0);
    tbl[1]  = mk(1, 8'h31, 1, 8'h62, 1, 0, 1, 8'h30, 0);
    tbl[2]  = mk(1, 8'h32, 1, 8'h63, 1, 0, 1, 8'h61, 0);
    tbl[3]  = mk(1, 8'h33, 1, 8'h64, 1, 0, 1, 8'h31, 0);
    tbl[4]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 1, 8'h62, 0);
    tbl[5]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 1, 8'h32, 0);
    tbl[6]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 1, 8'h63, 0);
    tbl[7]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 1, 8'h33, 0);
    tbl[8]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 1, 8'h64, 0);
    tbl[9]  = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 8'h00, 0);
    // CSI sequence keeps the keyboard byte out until the final byte.
    tbl[10] = mk(1, 8'h1B, 1, 8'h78, 1, 0, 0, 8'h00, 0);
    tbl[11] = mk(1, 8'h5B, 0, 8'h00, 1, 0, 1, 8'h1B, 1);
    tbl[12] = mk(1, 8'h32, 0, 8'h00, 1, 0, 1, 8'h5B, 1);
    tbl[13] = mk(1, 8'h4A, 0, 8'h00, 1, 0, 1, 8'h32, 1);
    tbl[14] = mk(0, 8'h00, 0, 8'h00, 1, 0, 1, 8'h4A, 0);
    tbl[15] = mk(0, 8'h00, 0, 8'h00, 1, 0, 1, 8'h78, 0);
    tbl[16] = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 8'h00, 0);
    // Single byte latency: push at N, visible at N+2, gone at N+3.
    tbl[17] = mk(1, 8'h41, 0, 8'h00, 1, 0, 0, 8'h00, 0);
    tbl[18] = mk(0, 8'h00, 0, 8'h00, 1, 0, 1, 8'h41, 0);
    tbl[19] = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 8'h00, 0);
    // Two-byte escape: ESC followed by a non-'[' byte releases the lock.
    tbl[20] = mk(1, 8'h1B, 0, 8'h00, 1, 0, 0, 8'h00, 0);
    tbl[21] = mk(1, 8'h63, 0, 8'h00, 1, 0, 1, 8'h1B, 1);
    tbl[22] = mk(0, 8'h00, 0, 8'h00, 1, 0, 1, 8'h63, 0);
    tbl[23] = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 8'h00, 0);
    // ESC inside CSI re-enters ESC; od held while odReady is low.
    tbl[24] = mk(1, 8'h1B, 0, 8'h00, 1, 0, 0, 8'h00, 0);
    tbl[25] = mk(1, 8'h5B, 0, 8'h00, 1, 0, 1, 8'h1B, 1);
    tbl[26] = mk(1, 8'h1B, 0, 8'h00, 1, 0, 1, 8'h5B, 1);
    tbl[27] = mk(1, 8'h41, 0, 8'h00, 0, 0, 1, 8'h5B, 1);
    tbl[28] = mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 8'h5B, 1);
    tbl[29] = mk(0, 8'h00, 0, 8'h00, 1, 0, 1, 8'h1B, 1);
    tbl[30] = mk(0, 8'h00, 0, 8'h00, 1, 0, 1, 8'h41, 0);
    tbl[31] = mk(0, 8'h00, 0, 8'h00, 1, 0, 0, 8'h00, 0);

    // Reset values
    resetn = 1'b0; d0 = 8'h00; d0v = 1'b0; d1 = 8'h00; d1v = 1'b0;
    odReady = 1'b1; errClr = 1'b0;
    step(); step();
    chk("rst od", od, 8'h00);
    chk("rst odv", odv, 0);
    chk("rst ovf0", ovf0, 0);
    chk("rst ovf1", ovf1, 0);
    chk("rst lockTimeout", lockTimeout, 0);
    chk("rst locked", locked, 0);
    resetn = 1'b1;
    step();

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      d0v = tbl[i].d0v; d0 = tbl[i].d0; d1v = tbl[i].d1v; d1 = tbl[i].d1;
      odReady = tbl[i].rdy; errClr = tbl[i].clr;
      step();
      chk($sformatf("vec%0d odv", i), odv, tbl[i].eOdv);
      if (tbl[i].eOdv) chk($sformatf("vec%0d od", i), od, tbl[i].eOd);
      chk($sformatf("vec%0d locked", i), locked, tbl[i].eLk);
    end
    d0v = 1'b0; d1v = 1'b0; odReady = 1'b1; errClr = 1'b0;

    // Lock timeout: ESC with no follow-up, keyboard byte waits for the release.
    d0 = 8'h1B; d0v = 1'b1;
    step();
    d0v = 1'b0; d1 = 8'h79; d1v = 1'b1;
    step();
    d1v = 1'b0;
    chk("to esc od", od, 8'h1B);
    chk("to esc locked", locked, 1);
    c = 0; sawEarly = 1'b0;
    while (!lockTimeout && c < 100) begin
      step();
      c++;
      if (odv && od == 8'h79 && !lockTimeout) sawEarly = 1'b1;
    end
    chk("to cycles", c, LT);
    chk("to locked at pulse", locked, 0);
    chk("to early kbd byte", sawEarly, 0);
    step();
    chk("to pulse width", lockTimeout, 0);
    chk("to kbd odv", odv, 1);
    chk("to kbd od", od, 8'h79);
    extra = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (lockTimeout) extra++;
    end
    chk("to extra pulses", extra, 0);

    // Overflow on source 1 with odReady low
    odReady = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      d1 = 8'hA0 + 8'(i); d1v = 1'b1;
      step();
    end
    d1v = 1'b0;
    chk("ovf ovf1 set", ovf1, 1);
    chk("ovf ovf0 clean", ovf0, 0);
    chk("ovf held od", od, 8'hA0);
    chk("ovf held odv", odv, 1);
    d1 = 8'hEE; d1v = 1'b1; errClr = 1'b1;
    step();
    chk("ovf set beats clear", ovf1, 1);
    d1v = 1'b0;
    step();
    chk("ovf cleared", ovf1, 0);
    errClr = 1'b0;
    // Drain; the first drain cycle pushes into the full FIFO while it pops.
    odReady = 1'b1; d1 = 8'hBB; d1v = 1'b1;
    step();
    d1v = 1'b0;
    chk("drain A1", od, 8'hA1);
    for (int i = 2; i <= DEPTH; i++) begin
      step();
      chk($sformatf("drain A%0d", i), od, 8'hA0 + 8'(i));
    end
    step();
    chk("drain BB", od, 8'hBB);
    chk("drain no ovf", ovf1, 0);
    step();
    chk("drain empty", odv, 0);

    // Reset while locked with an overflow pending
    odReady = 1'b0; d0 = 8'h1B; d0v = 1'b1;
    step();
    for (int i = 0; i < DEPTH + 2; i++) begin
      d0 = 8'hC0 + 8'(i);
      step();
    end
    d0v = 1'b0;
    chk("prerst locked", locked, 1);
    chk("prerst ovf0", ovf0, 1);
    chk("prerst odv", odv, 1);
    #2 resetn = 1'b0;
    #1;
    chk("midrst odv", odv, 0);
    chk("midrst locked", locked, 0);
    chk("midrst ovf0", ovf0, 0);
    chk("midrst od", od, 8'h00);
    step();
    resetn = 1'b1; odReady = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (odv) stale = 1'b1;
    end
    chk("postrst no stale", stale, 0);
    chk("postrst locked", locked, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
